// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU/mux encodings, FSM state codes.
// Defining CTRL_ADDI_EN adds the addi execute/writeback state codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_RESET_IDLE = 4'd0,
    ST_FETCH      = 4'd1,
    ST_DECODE     = 4'd2,
    ST_MEM_ADDR   = 4'd3,
    ST_MEM_READ   = 4'd4,
    ST_MEM_WB     = 4'd5,
    ST_MEM_WRITE  = 4'd6,
    ST_EXEC       = 4'd7,
    ST_R_WB       = 4'd8,
    ST_BRANCH     = 4'd9,
    ST_JUMP       = 4'd10
`ifdef CTRL_ADDI_EN
    ,
    ST_ADDI_WB    = 4'd11,
    ST_ADDI_EXEC  = 4'd12
`endif
  } state_t;

endpackage

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: Moore FSM with mem_ready-gated fetch strobes; outputs decode from state.
// Optional addi support when CTRL_ADDI_EN is defined; otherwise addi raises illegal_op.
module mips_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET_IDLE;
    else        state <= next_state;
  end

  assign state_dbg = state;

  always_comb begin
    next_state  = ST_FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    case (state)
      ST_RESET_IDLE: next_state = ST_FETCH;
      ST_FETCH: begin
        // PC+4 and IR load commit only on the cycle memory delivers the word
        memread    = 1'b1;
        alusrcb    = SRCB_FOUR;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
        next_state = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     next_state = ST_EXEC;
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      next_state = ST_ADDI_EXEC;
`endif
          default: begin
            illegal_op = 1'b1;
            next_state = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        memread    = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      end
      ST_MEM_WB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      ST_MEM_WRITE: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      end
      ST_EXEC: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = ST_R_WB;
      end
      ST_R_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      ST_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
`ifdef CTRL_ADDI_EN
      ST_ADDI_EXEC: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = ST_ADDI_WB;
      end
      ST_ADDI_WB: regwrite = 1'b1;
`endif
      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: queue-based instruction model, directed latency checks, random run.
module tb_mips_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state_dbg;

  mips_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MREAD = 4, S_MWB = 5;
  localparam int S_MWR = 6, S_EXEC = 7, S_RWB = 8, S_BR = 9, S_J = 10, S_AWB = 11, S_AEX = 12;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsource,illegal_op,state}
  logic [20:0] dut_v;
  assign dut_v = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                  regwrite, alusrca, alusrcb, aluop, pcsource, illegal_op, state_dbg};

  int checks = 0;
  int errors = 0;
  int m_state = S_IDLE;
  int plan[$];
  int waits_left = 0;
  logic rand_mr = 1'b0;
  logic [20:0] obs[16];
  int st_cnt[16];

  function automatic logic legal(input logic [5:0] op);
    logic ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b000010);
`ifdef CTRL_ADDI_EN
    if (op == 6'b001000) ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic logic [20:0] exp_vec(input int st, input logic mr, input logic [5:0] op);
    logic [20:0] v;
    v = '0;
    case (st)
      S_FETCH:  begin v[17] = 1'b1; v[10:9] = 2'b01; v[15] = mr; v[20] = mr; end
      S_DECODE: begin v[10:9] = 2'b11; v[4] = !legal(op); end
      S_MADDR:  begin v[11] = 1'b1; v[10:9] = 2'b10; end
      S_MREAD:  begin v[17] = 1'b1; v[18] = 1'b1; end
      S_MWB:    begin v[12] = 1'b1; v[14] = 1'b1; end
      S_MWR:    begin v[16] = 1'b1; v[18] = 1'b1; end
      S_EXEC:   begin v[11] = 1'b1; v[8:7] = 2'b10; end
      S_RWB:    begin v[12] = 1'b1; v[13] = 1'b1; end
      S_BR:     begin v[11] = 1'b1; v[8:7] = 2'b01; v[19] = 1'b1; v[6:5] = 2'b01; end
      S_J:      begin v[20] = 1'b1; v[6:5] = 2'b10; end
      S_AEX:    begin v[11] = 1'b1; v[10:9] = 2'b10; end
      S_AWB:    v[12] = 1'b1;
      default:  v = '0;
    endcase
    v[3:0] = 4'(st);
    return v;
  endfunction

  // The decode step queues the whole remaining step list of the instruction.
  task automatic model_step();
    case (m_state)
      S_IDLE:  m_state = S_FETCH;
      S_FETCH: if (mem_ready) m_state = S_DECODE;
      default: begin
        if (m_state == S_DECODE) begin
          plan.delete();
          case (opcode)
            6'b000000: plan = '{S_EXEC, S_RWB};
            6'b100011: plan = '{S_MADDR, S_MREAD, S_MWB};
            6'b101011: plan = '{S_MADDR, S_MWR};
            6'b000100: plan = '{S_BR};
            6'b000010: plan = '{S_J};
`ifdef CTRL_ADDI_EN
            6'b001000: plan = '{S_AEX, S_AWB};
`endif
            default: plan.delete();
          endcase
        end
        if ((m_state == S_MREAD || m_state == S_MWR) && !mem_ready) m_state = m_state;
        else if (plan.size() > 0) m_state = plan.pop_front();
        else m_state = S_FETCH;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [5:0] op);
    logic mr;
    @(posedge clk);
    model_step();
    #1;
    if (rand_mr) mr = 1'($urandom_range(0, 1));
    else if ((m_state == S_MREAD || m_state == S_MWR) && waits_left > 0) begin
      mr = 1'b0;
      waits_left--;
    end else mr = 1'b1;
    opcode = op;
    mem_ready = mr;
    @(negedge clk);
    check("outputs", {11'd0, dut_v}, {11'd0, exp_vec(m_state, mem_ready, opcode)});
  endtask

  // Runs from the current FETCH cycle until the model is back in FETCH.
  task automatic run_instr(input logic [5:0] op, input int waits, output int cyc,
                           output int ill_cnt, output logic any_rw);
    logic done;
    cyc = 1; ill_cnt = 0; any_rw = 1'b0; done = 1'b0;
    waits_left = waits;
    for (int i = 0; i < 16; i++) begin obs[i] = '0; st_cnt[i] = 0; end
    for (int k = 0; k < 200 && !done; k++) begin
      cycle(op);
      if (dut_v[4]) ill_cnt++;
      if (dut_v[12]) any_rw = 1'b1;
      obs[m_state] = dut_v;
      st_cnt[m_state]++;
      if (m_state == S_FETCH) done = 1'b1;
      else cyc++;
    end
    if (!done) check("instr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, ill;
    logic rw;
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    #2 check("reset_outputs", {11'd0, dut_v}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(6'd0);
    check("after_reset_fetch", {28'd0, state_dbg}, 32'd1);

    run_instr(6'b000000, 0, cyc, ill, rw);
    check("r_latency", cyc, 4);
    check("r_exec_aluop", {30'd0, obs[S_EXEC][8:7]}, 32'd2);
    check("r_wb_regwrite_regdst", {30'd0, obs[S_RWB][12], obs[S_RWB][13]}, 32'd3);

    run_instr(6'b100011, 2, cyc, ill, rw);
    check("lw_latency_2wait", cyc, 7);
    check("lw_memread_cycles", st_cnt[S_MREAD], 3);
    check("lw_memtoreg", {31'd0, obs[S_MWB][14]}, 32'd1);

    run_instr(6'b101011, 0, cyc, ill, rw);
    check("sw_latency", cyc, 4);
    check("sw_memwrite_iord", {30'd0, obs[S_MWR][16], obs[S_MWR][18]}, 32'd3);
    check("sw_no_regwrite", {31'd0, rw}, 32'd0);

    run_instr(6'b000100, 0, cyc, ill, rw);
    check("beq_latency", cyc, 3);
    check("beq_pcwritecond", {31'd0, obs[S_BR][19]}, 32'd1);
    check("beq_aluop", {30'd0, obs[S_BR][8:7]}, 32'd1);

    run_instr(6'b000010, 0, cyc, ill, rw);
    check("j_latency", cyc, 3);
    check("j_pcwrite_pcsource", {29'd0, obs[S_J][20], obs[S_J][6:5]}, 32'b110);

    run_instr(6'b111111, 0, cyc, ill, rw);
    check("illegal_pulses", ill, 1);
    check("illegal_latency", cyc, 2);

    run_instr(6'b001000, 0, cyc, ill, rw);
`ifdef CTRL_ADDI_EN
    check("addi_latency", cyc, 4);
    check("addi_wb_regwrite_regdst", {30'd0, obs[S_AWB][12], obs[S_AWB][13]}, 32'd2);
`else
    check("addi_illegal", ill, 1);
    check("addi_latency_illegal", cyc, 2);
`endif

    // Reset while an R-type is in EXEC
    cycle(6'b000000);
    cycle(6'b000000);
    check("in_exec_before_reset", {28'd0, state_dbg}, 32'd7);
    rst_n = 1'b0;
    #1 check("reset_mid_exec", {11'd0, dut_v}, 32'd0);
    m_state = S_IDLE;
    plan.delete();
    @(posedge clk); #1 check("reset_held", {11'd0, dut_v}, 32'd0);
    rst_n = 1'b1;
    cycle(6'b000000);
    check("fetch_after_release", {28'd0, state_dbg}, 32'd1);

    rand_mr = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 6) == 0) op = 6'($urandom);
      run_instr(op, 0, cyc, ill, rw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
